// File: rtl/bcd_serial_converter.sv
// Serial binary-to-BCD converter (shift-add-3, one bit per clock) feeding the
// four-digit 7-segment decoders with registered digits, sign and overflow flags.
module bcd_serial_converter #(
   parameter int WIDTH   = 16,
   parameter bit SAT_OVF = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] value,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             neg,
   output logic             ovf,
   output logic [3:0]       thousand,
   output logic [3:0]       hundred,
   output logic [3:0]       ten,
   output logic [3:0]       one
);

   localparam int BCD_W = 20;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

   state_t           state;
   logic [BCD_W-1:0] bcd;
   logic [BCD_W-1:0] bcd_adj;
   logic [WIDTH-1:0] mag;
   logic [CNT_W-1:0] cnt;
   logic             neg_l;
   logic             value_neg;

   function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] res;
      res = acc;
      for (int n = 0; n < BCD_W / 4; n++) begin
         if (acc[n*4 +: 4] >= 4'd5)
            res[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
      end
      return res;
   endfunction

   // Ten-thousands nibble non-zero means the magnitude exceeds four digits.
   function automatic logic [15:0] select_digits(input logic [BCD_W-1:0] acc);
      if ((acc[19:16] != 4'd0) && SAT_OVF)
         return 16'h9999;
      else
         return acc[15:0];
   endfunction

   always_comb begin
      bcd_adj   = add3_nibbles(bcd);
      value_neg = signed_mode & value[WIDTH-1];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         neg      <= 1'b0;
         ovf      <= 1'b0;
         thousand <= 4'd0;
         hundred  <= 4'd0;
         ten      <= 4'd0;
         one      <= 4'd0;
         bcd      <= '0;
         mag      <= '0;
         cnt      <= '0;
         neg_l    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  neg_l <= value_neg;
                  mag   <= value_neg ? (~value + WIDTH'(1)) : value;
                  bcd   <= '0;
                  cnt   <= CNT_W'(WIDTH);
                  busy  <= 1'b1;
                  state <= CONVERT;
               end
            end
            CONVERT: begin
               bcd <= BCD_W'({bcd_adj, mag[WIDTH-1]});
               mag <= mag << 1;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= FINISH;
            end
            FINISH: begin
               ovf <= (bcd[19:16] != 4'd0);
               {thousand, hundred, ten, one} <= select_digits(bcd);
               neg   <= neg_l;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed bench for bcd_serial_converter: one saturating and one wrapping
// instance driven by the same stimulus, checked with immediate assertions.
module tb_bcd_serial_converter;

   logic        clock;
   logic        reset;
   logic        start;
   logic [15:0] value;
   logic        signed_mode;

   logic        busy_s, done_s, neg_s, ovf_s;
   logic [3:0]  th_s, hu_s, te_s, on_s;
   logic        busy_w, done_w, neg_w, ovf_w;
   logic [3:0]  th_w, hu_w, te_w, on_w;
   logic [15:0] dig_s, dig_w;

   int checks = 0;
   int errors = 0;

   assign dig_s = {th_s, hu_s, te_s, on_s};
   assign dig_w = {th_w, hu_w, te_w, on_w};

   bcd_serial_converter #(.WIDTH(16), .SAT_OVF(1'b1)) dut_s (
      .clock(clock), .reset(reset), .start(start), .value(value),
      .signed_mode(signed_mode), .busy(busy_s), .done(done_s), .neg(neg_s),
      .ovf(ovf_s), .thousand(th_s), .hundred(hu_s), .ten(te_s), .one(on_s)
   );

   bcd_serial_converter #(.WIDTH(16), .SAT_OVF(1'b0)) dut_w (
      .clock(clock), .reset(reset), .start(start), .value(value),
      .signed_mode(signed_mode), .busy(busy_w), .done(done_w), .neg(neg_w),
      .ovf(ovf_w), .thousand(th_w), .hundred(hu_w), .ten(te_w), .one(on_w)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy_s"}, 32'(busy_s), 32'd0);
      chk({tag, "_done_s"}, 32'(done_s), 32'd0);
      chk({tag, "_neg_s"},  32'(neg_s),  32'd0);
      chk({tag, "_ovf_s"},  32'(ovf_s),  32'd0);
      chk({tag, "_dig_s"},  32'(dig_s),  32'd0);
      chk({tag, "_busy_w"}, 32'(busy_w), 32'd0);
      chk({tag, "_dig_w"},  32'(dig_w),  32'd0);
   endtask

   // Start at edge k, check busy/hold through k+16, results at k+17, done drop at k+18.
   task automatic run_conv(input string tag, input logic [15:0] v, input logic sm,
                           input logic [15:0] e_sat, input logic [15:0] e_wrap,
                           input logic e_neg, input logic e_ovf);
      logic [15:0] held_s, held_w;
      held_s = dig_s;
      held_w = dig_w;
      start = 1'b1; value = v; signed_mode = sm;
      step();
      start = 1'b0; value = 16'($urandom); signed_mode = ~sm;
      chk({tag, "_busy_k"}, 32'(busy_s), 32'd1);
      for (int i = 1; i <= 16; i++) begin
         step();
         chk({tag, "_busy_mid"}, 32'(busy_s), 32'd1);
         chk({tag, "_done_mid"}, 32'(done_s), 32'd0);
         chk({tag, "_hold_s"},   32'(dig_s),  32'(held_s));
         chk({tag, "_hold_w"},   32'(dig_w),  32'(held_w));
      end
      step();
      chk({tag, "_done"},   32'(done_s), 32'd1);
      chk({tag, "_busy"},   32'(busy_s), 32'd0);
      chk({tag, "_dig_s"},  32'(dig_s),  32'(e_sat));
      chk({tag, "_neg"},    32'(neg_s),  32'(e_neg));
      chk({tag, "_ovf"},    32'(ovf_s),  32'(e_ovf));
      chk({tag, "_done_w"}, 32'(done_w), 32'd1);
      chk({tag, "_dig_w"},  32'(dig_w),  32'(e_wrap));
      chk({tag, "_neg_w"},  32'(neg_w),  32'(e_neg));
      chk({tag, "_ovf_w"},  32'(ovf_w),  32'(e_ovf));
      step();
      chk({tag, "_done_drop"}, 32'(done_s), 32'd0);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; value = 16'd0; signed_mode = 1'b0;
      step();
      step();
      chk_all_zero("reset");
      reset = 1'b1;
      step();

      run_conv("u1234",  16'd1234, 1'b0, 16'h1234, 16'h1234, 1'b0, 1'b0);
      run_conv("sFFFF",  16'hFFFF, 1'b1, 16'h0001, 16'h0001, 1'b1, 1'b0);
      run_conv("uFFFF",  16'hFFFF, 1'b0, 16'h9999, 16'h5535, 1'b0, 1'b1);
      run_conv("s8000",  16'h8000, 1'b1, 16'h9999, 16'h2768, 1'b1, 1'b1);
      run_conv("szero",  16'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);

      // Mid-conversion start ignored; start during done cycle accepted.
      start = 1'b1; value = 16'h0009; signed_mode = 1'b0;
      step();
      start = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (i == 5) begin
            start = 1'b1; value = 16'h0FFF;
         end else begin
            start = 1'b0;
         end
         step();
         chk("ign_done_mid", 32'(done_s), 32'd0);
         chk("ign_busy_mid", 32'(busy_s), 32'd1);
      end
      start = 1'b0;
      step();
      chk("ign_done", 32'(done_s), 32'd1);
      chk("ign_dig",  32'(dig_s),  32'h0009);
      start = 1'b1; value = 16'h03E7;
      step();
      start = 1'b0;
      chk("b2b_busy_k", 32'(busy_s), 32'd1);
      chk("b2b_done_clr", 32'(done_s), 32'd0);
      for (int i = 1; i <= 16; i++) begin
         step();
         chk("b2b_done_mid", 32'(done_s), 32'd0);
         chk("b2b_hold", 32'(dig_s), 32'h0009);
      end
      step();
      chk("b2b_done", 32'(done_s), 32'd1);
      chk("b2b_dig",  32'(dig_s),  32'h0999);
      chk("b2b_ovf",  32'(ovf_s),  32'd0);
      step();

      // Reset at edge k+8 aborts a conversion of 10000.
      start = 1'b1; value = 16'h2710; signed_mode = 1'b0;
      step();
      start = 1'b0;
      for (int i = 1; i <= 7; i++) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk_all_zero("abort");
      for (int i = 0; i < 20; i++) begin
         step();
         chk("abort_no_done_s", 32'(done_s), 32'd0);
         chk("abort_no_done_w", 32'(done_w), 32'd0);
         chk("abort_idle",      32'(busy_s), 32'd0);
      end

      run_conv("u10000", 16'h2710, 1'b0, 16'h9999, 16'h0000, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bcd_serial_converter.md
Name: bcd_serial_converter

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the four-digit 7-segment output stage.
- Captures a 16-bit processor OUT value on a start strobe and runs an iterative shift-add-3 (double dabble), one bit per clock.
- Presents registered thousand/hundred/ten/one digits plus sign and overflow flags, which feed the digit decoders. A negative value drives the sign indication on the thousands display.

Parameters:
- WIDTH, 16: input value width; also the number of conversion iterations.
- SAT_OVF, 1: 1 = on overflow, digits saturate to 9,9,9,9; 0 = on overflow, digits show the low four decimal digits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only in IDLE.
- value  in  WIDTH  binary value to convert.
- signed_mode  in  1  1 = value is two's complement; 0 = value is unsigned.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when the outputs update.
- neg  out  1  result is negative.
- ovf  out  1  magnitude > 9999.
- thousand  out  4  BCD thousands digit.
- hundred  out  4  BCD hundreds digit.
- ten  out  4  BCD tens digit.
- one  out  4  BCD ones digit.

Behaviour:
- Reset (reset==0 at a rising edge):
  - State goes to IDLE; busy=0, done=0, neg=0, ovf=0, all digits=0.
  - The internal shift register and counter are cleared.
  - Reset during CONVERT aborts the conversion; no done pulse follows.
- States: IDLE, CONVERT, FINISH.
- IDLE, edge k with start==1:
  - Latch neg_l = signed_mode & value[WIDTH-1].
  - Latch mag = neg_l ? (~value + 1) : value, taken modulo 2^WIDTH. -32768 yields magnitude 32768.
  - Clear the 20-bit BCD accumulator (5 nibbles); set the counter to WIDTH.
  - busy=1; go to CONVERT.
- CONVERT, edges k+1..k+WIDTH:
  - Add 3 to each accumulator nibble >= 5.
  - Then shift {bcd, mag} left by 1; the mag MSB enters the BCD LSB.
  - Decrement the counter; on the edge that reaches 0, go to FINISH.
- FINISH, edge k+WIDTH+1:
  - ovf = (ten-thousands nibble != 0).
  - If ovf && SAT_OVF, digits = 9,9,9,9; otherwise digits = the low four nibbles.
  - neg = neg_l; done=1 for exactly this one cycle; busy=0; go to IDLE.
- Latency: 17 clocks from the start-sampling edge to done (WIDTH=16). busy is high for 17 cycles.
- Digit, neg and ovf outputs change only on the FINISH edge or on reset; they hold between conversions.
- start while busy is ignored and is not queued.
- start high during the done cycle is accepted at the next edge (IDLE), allowing back-to-back conversions every 18 cycles.
- value and signed_mode are don't-care after the start-sampling edge.
- Zero input: digits 0,0,0,0; neg=0 (no negative zero).

Test Plan:
- Unsigned, value=16'd1234, start pulse at edge k:
  - busy high edges k..k+16.
  - At edge k+17: done=1 for one cycle; digits 1,2,3,4; neg=0; ovf=0.
- Signed, value=16'hFFFF: neg=1; digits 0,0,0,1; ovf=0.
- Unsigned, value=16'hFFFF:
  - SAT_OVF=1: ovf=1, digits 9,9,9,9.
  - SAT_OVF=0 build: ovf=1, digits 5,5,3,5.
- Signed, value=16'h8000: magnitude 32768; neg=1; ovf=1; digits 9,9,9,9 with SAT_OVF=1.
- Start 0x0009, then pulse start with value=0x0FFF at edge k+5 (mid-conversion): ignored. Single done at k+17 with 0,0,0,9. A start asserted during the done cycle with 0x03E7 yields 0,9,9,9 eighteen cycles later.
- Assert reset at edge k+8 of a conversion of 0x2710: all outputs 0, no done pulse. A subsequent start with 0x2710 gives ovf=1 (10000).
